// File: rtl/cfg_pkg.sv
// Shared constants, FSM state encoding and checksum helper for the tile configuration loader.
package cfg_pkg;

    localparam int TILE_BITS   = 77;
    localparam int FRAME_BYTES = 10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } state_e;

    function automatic logic [7:0] xor8(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/cfg_loader.sv
// Streams 10-byte frames into a 77-bit tile word and pulses a one-hot tile write per frame.
// Optional per-frame XOR checksum byte: define CFG_LOADER_CHECKSUM_EN.
module cfg_loader
    import cfg_pkg::*;
#(
    parameter int NUM_TILES = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [7:0]            data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [TILE_BITS-1:0]  bits_o,
    output logic [NUM_TILES-1:0]  wr_en_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int             TW        = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
    localparam int             TOP_LO    = 8 * (FRAME_BYTES - 1);
    localparam int             TOP_W     = TILE_BITS - TOP_LO;
    localparam logic [3:0]     LAST_BYTE = 4'(FRAME_BYTES - 1);
    localparam logic [TW-1:0]  LAST_TILE = TW'(NUM_TILES - 1);

    state_e                 state_q, state_d;
    logic [TW-1:0]          tile_q, tile_d;
    logic [3:0]             byte_q, byte_d;
    logic [TILE_BITS-1:0]   bits_q, bits_d;
`ifdef CFG_LOADER_CHECKSUM_EN
    logic [7:0]             csum_q, csum_d;
    logic                   err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        tile_d  = tile_q;
        byte_d  = byte_q;
        bits_d  = bits_q;
`ifdef CFG_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = LOAD;
                    tile_d  = '0;
                    byte_d  = '0;
`ifdef CFG_LOADER_CHECKSUM_EN
                    csum_d  = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            LOAD: begin
                if (valid_i) begin
                    for (int k = 0; k < FRAME_BYTES - 1; k++) begin
                        if (byte_q == 4'(k)) bits_d[8*k +: 8] = data_i;
                    end
                    // The last frame byte only partly fits; its upper bits are dropped.
                    if (byte_q == LAST_BYTE) bits_d[TILE_BITS-1:TOP_LO] = data_i[TOP_W-1:0];
`ifdef CFG_LOADER_CHECKSUM_EN
                    csum_d = xor8(csum_q, data_i);
`endif
                    byte_d = byte_q + 4'd1;
                    if (byte_q == LAST_BYTE) begin
`ifdef CFG_LOADER_CHECKSUM_EN
                        state_d = CHECK;
`else
                        state_d = WRITE;
`endif
                    end
                end
            end
`ifdef CFG_LOADER_CHECKSUM_EN
            CHECK: begin
                if (valid_i) begin
                    if (data_i == csum_q) begin
                        state_d = WRITE;
                    end else begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
            ERROR: state_d = IDLE;
`endif
            WRITE: begin
                byte_d = '0;
`ifdef CFG_LOADER_CHECKSUM_EN
                csum_d = '0;
`endif
                if (tile_q == LAST_TILE) begin
                    state_d = DONE;
                end else begin
                    tile_d  = tile_q + TW'(1);
                    state_d = LOAD;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            tile_q  <= '0;
            byte_q  <= '0;
            bits_q  <= '0;
`ifdef CFG_LOADER_CHECKSUM_EN
            csum_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tile_q  <= tile_d;
            byte_q  <= byte_d;
            bits_q  <= bits_d;
`ifdef CFG_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
            err_q   <= err_d;
`endif
        end
    end

`ifdef CFG_LOADER_CHECKSUM_EN
    assign ready_o = (state_q == LOAD) || (state_q == CHECK);
    assign busy_o  = (state_q == LOAD) || (state_q == CHECK) || (state_q == WRITE);
    assign err_o   = err_q;
`else
    assign ready_o = (state_q == LOAD);
    assign busy_o  = (state_q == LOAD) || (state_q == WRITE);
    assign err_o   = 1'b0;
`endif
    assign done_o  = (state_q == DONE);
    assign bits_o  = bits_q;

    for (genvar gi = 0; gi < NUM_TILES; gi++) begin : g_wr
        assign wr_en_o[gi] = (state_q == WRITE) && (tile_q == TW'(gi));
    end

endmodule

// File: tb/tb_cfg_loader.sv
// Directed table-driven bench for cfg_loader with two tiles.
module tb_cfg_loader;
    localparam int NT = 2;
`ifdef CFG_LOADER_CHECKSUM_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          valid = 1'b0;
    logic [7:0]    data = 8'h00;
    logic          ready_o, busy_o, done_o, err_o;
    logic [76:0]   bits_o;
    logic [NT-1:0] wr_en_o;

    cfg_loader #(.NUM_TILES(NT)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .data_i(data), .valid_i(valid),
        .ready_o(ready_o), .bits_o(bits_o), .wr_en_o(wr_en_o), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [79:0] frame;
        logic [76:0] exp;
    } vec_t;
    vec_t vecs [5];

    int          c0 = 0;
    int          log_cyc[$];
    logic [NT-1:0] log_wr[$];
    logic [76:0] log_bits[$];
    int          done_cyc[$];
    logic        chk_after = 1'b0;
    logic [76:0] wr_bits;

    always @(negedge clk) begin
        if (chk_after) begin
            check("bits_stable_after_wr", bits_o, wr_bits);
            chk_after = 1'b0;
        end
        if (wr_en_o != '0) begin
            check("wr_onehot", $countones(wr_en_o), 1);
            log_cyc.push_back(cyc - c0);
            log_wr.push_back(wr_en_o);
            log_bits.push_back(bits_o);
            wr_bits   = bits_o;
            chk_after = 1'b1;
        end
        if (done_o) done_cyc.push_back(cyc - c0);
    end

    function automatic logic [7:0] csum(input logic [79:0] f);
        logic [7:0] c = 8'h00;
        for (int k = 0; k < 10; k++) c = c ^ f[8*k +: 8];
        return c;
    endfunction

    function automatic logic [7:0] frame_byte(input logic [79:0] f, input int k);
        if (k < 10) return f[8*k +: 8];
        return csum(f);
    endfunction

    // Called just after a rising edge; returns just after the edge that took the byte.
    task automatic send_byte(input logic [7:0] b, input bit throttle, input bit poke);
        bit took = 1'b0;
        valid = 1'b1;
        data  = b;
        if (poke) start = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (ready_o) begin
                took = 1'b1;
                check("busy_in_load", busy_o, 1'b1);
                break;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        if (!took) check("byte_accept_timeout", 0, 1);
        @(posedge clk); #1;
        start = 1'b0;
        if (throttle) begin
            valid = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic begin_pass();
        log_cyc.delete(); log_wr.delete(); log_bits.delete(); done_cyc.delete();
        start = 1'b1;
        c0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_pass(input int idx, input vec_t v0, input vec_t v1, input bit throttle, input bit poke);
        begin_pass();
        for (int k = 0; k < FB; k++) send_byte(frame_byte(v0.frame, k), throttle, poke && k == 3);
        for (int k = 0; k < FB; k++) send_byte(frame_byte(v1.frame, k), throttle, 1'b0);
        valid = 1'b0;
        for (int i = 0; i < 60 && done_cyc.size() == 0; i++) @(negedge clk);
        check("done_seen", done_cyc.size(), 1);
        check("wr_count", log_wr.size(), 2);
        if (log_wr.size() == 2) begin
            check("wr_tile0", log_wr[0], 2'b01);
            check("wr_tile1", log_wr[1], 2'b10);
            check("bits_tile0", log_bits[0], v0.exp);
            check("bits_tile1", log_bits[1], v1.exp);
            if (!throttle) begin
                check("wr_cycle0", log_cyc[0], FB + 1);
                check("wr_cycle1", log_cyc[1], 2 * (FB + 1));
            end
        end
        if (done_cyc.size() == 1 && !throttle) check("done_cycle", done_cyc[0], 2 * (FB + 1) + 1);
        @(negedge clk);
        check("idle_busy", busy_o, 1'b0);
        check("idle_ready", ready_o, 1'b0);
        check("idle_done", done_o, 1'b0);
        $display("pass %0d: throttle=%0b start_poke=%0b writes=%0d done=%0d", idx, throttle, poke,
                 log_wr.size(), done_cyc.size());
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, ready_o, 1'b0);
        check({tag, "_busy"}, busy_o, 1'b0);
        check({tag, "_done"}, done_o, 1'b0);
        check({tag, "_err"}, err_o, 1'b0);
        check({tag, "_wr"}, wr_en_o, '0);
        check({tag, "_bits"}, bits_o, '0);
    endtask

    initial begin
        vecs[0] = '{frame: 80'hFA_0908_0706_0504_0302_01, exp: 77'h1A_0908_0706_0504_0302_01};
        vecs[1] = '{frame: 80'hFF_FFFF_FFFF_FFFF_FFFF_FF, exp: 77'h1F_FFFF_FFFF_FFFF_FFFF_FF};
        vecs[2] = '{frame: 80'h00_0000_0000_0000_0000_00, exp: 77'h00_0000_0000_0000_0000_00};
        vecs[3] = '{frame: 80'hE0_ABCD_EF01_2345_6789_A5, exp: 77'h00_ABCD_EF01_2345_6789_A5};
        vecs[4] = '{frame: 80'h3F_8080_8080_8080_8080_80, exp: 77'h1F_8080_8080_8080_8080_80};

        valid = 1'b1;
        data  = 8'h5A;
        repeat (2) @(negedge clk);
        check_all_zero("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("idle_valid_no_consume");
        valid = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++)
            run_pass(i, vecs[i], vecs[(i + 1) % 5], i[0], i == 2);

        // Reset after byte 5 of tile 1: tile 0 written, tile 1 must never be written.
        begin_pass();
        for (int k = 0; k < FB; k++) send_byte(frame_byte(vecs[1].frame, k), 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) send_byte(frame_byte(vecs[2].frame, k), 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        valid = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_reset_wr_count", log_wr.size(), 1);
        $display("reset abort: writes=%0d", log_wr.size());
        @(posedge clk); #1;
        run_pass(5, vecs[3], vecs[0], 1'b0, 1'b0);

`ifdef CFG_LOADER_CHECKSUM_EN
        begin_pass();
        for (int k = 0; k < 10; k++) send_byte(frame_byte(vecs[0].frame, k), 1'b0, 1'b0);
        send_byte(csum(vecs[0].frame) ^ 8'h01, 1'b0, 1'b0);
        valid = 1'b0;
        @(negedge clk);
        check("err_set", err_o, 1'b1);
        check("err_busy", busy_o, 1'b0);
        repeat (4) @(negedge clk);
        check("err_held", err_o, 1'b1);
        check("err_idle_ready", ready_o, 1'b0);
        check("err_no_wr", log_wr.size(), 0);
        $display("checksum error: err=%0b writes=%0d", err_o, log_wr.size());
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("err_cleared_by_start", err_o, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/cfg_loader.md
CFG_LOADER -- requirements
Module: cfg_loader

Interface
REQ-001 The block SHALL have parameter NUM_TILES, default 4, number of tiles in the configuration chain (1..16).
REQ-002 The block SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port start_i  input  1  one-cycle request to begin a configuration pass.
REQ-005 The block SHALL have port data_i  input  8  bitstream byte.
REQ-006 The block SHALL have port valid_i  input  1  data_i valid.
REQ-007 The block SHALL have port ready_o  output  1  byte accepted when valid_i && ready_o.
REQ-008 The block SHALL have port bits_o  output  77  assembled tile configuration word, driving the tile bits input.
REQ-009 The block SHALL have port wr_en_o  output  NUM_TILES  one-hot tile write enable.
REQ-010 The block SHALL have port busy_o  output  1  pass in progress.
REQ-011 The block SHALL have port done_o  output  1  one-cycle pulse after the last tile is written.
REQ-012 The block SHALL have port err_o  output  1  sticky error flag.

Function
REQ-013 Frame SHALL be 10 bytes per tile, LSB first: byte k supplies bits_o[8k+7:8k]; bits 79:77 of byte 9 are discarded.
REQ-014 FSM states SHALL be IDLE, LOAD, CHECK (macro-dependent), WRITE, DONE, ERROR.
REQ-015 IDLE: ready_o=0; start_i moves to LOAD with tile index 0, byte count 0, and err_o cleared.
REQ-016 LOAD: ready_o=1; each accepted byte writes its slice of bits_o and increments byte count; byte 9 accepted -> WRITE (or CHECK when enabled).
REQ-017 WRITE: exactly one cycle, wr_en_o[tile index]=1, ready_o=0, bits_o unchanged; then tile index increments and byte count clears.
REQ-018 Latency: final frame byte accepted in cycle N SHALL give wr_en_o high in cycle N+1.
REQ-019 After WRITE of tile NUM_TILES-1, the FSM SHALL go to DONE: done_o=1 for one cycle, then IDLE.
REQ-020 bits_o SHALL change only on an accepted byte in LOAD, so it is stable in the cycle before, during, and after every wr_en_o pulse.
REQ-021 wr_en_o SHALL be all-zero outside WRITE and never have more than one bit set.
REQ-022 busy_o SHALL be 1 in LOAD, CHECK and WRITE, and 0 in IDLE, DONE and ERROR.
REQ-023 start_i SHALL be ignored unless in IDLE.
REQ-024 valid_i without ready_o SHALL have no effect; bytes in IDLE are not consumed.
REQ-025 Tile index and byte count SHALL NOT wrap; a pass ends after exactly NUM_TILES frames.

Reset
REQ-026 While rst_ni=0 the FSM SHALL be IDLE, and bits_o, wr_en_o, the counters, ready_o, busy_o, done_o and err_o SHALL be 0.
REQ-027 Reset mid-pass SHALL abort with no wr_en_o pulse; already-written tiles are not rolled back.

Configuration
REQ-028 Macro CFG_LOADER_CHECKSUM_EN, when defined, SHALL append an 11th byte to each frame equal to the XOR of the 10 frame bytes, accepted in CHECK.
REQ-029 With the macro defined, a checksum match SHALL go to WRITE; a mismatch SHALL go to ERROR with no write, set err_o, then go to IDLE next cycle.
REQ-030 Without the macro, CHECK, the checksum logic and the ERROR path SHALL be absent, and err_o SHALL be tied to 0.

Structure
REQ-031 Package cfg_pkg SHALL hold TILE_BITS=77, FRAME_BYTES=10, the FSM state enum and the xor8 checksum function.
REQ-032 The block SHALL be one module with no sub-modules; the tile array instantiates it once and fans wr_en_o out per tile.

Verification
REQ-033 NUM_TILES=2, 20 bytes streamed with valid_i held high -> wr_en_o=01 in cycle 11, wr_en_o=10 in cycle 22, done_o pulse in cycle 23.
REQ-034 Bytes 0x01..0x0A, with byte 9=0xFA -> bits_o = 77'h1A_0908_0706_0504_0302_01 (bits 79:77 dropped) when wr_en_o is high.
REQ-035 valid_i toggled 1/0 every cycle -> every byte is accepted, with no duplicates or drops, and the same bits_o as the unthrottled run.
REQ-036 rst_ni pulsed low after byte 5 of tile 1 -> no wr_en_o for tile 1, all outputs 0, and a fresh start_i rewrites from tile 0.
REQ-037 CFG_LOADER_CHECKSUM_EN defined, checksum byte corrupted (XOR 0x01) -> no wr_en_o, err_o=1 held until next start_i, FSM returns to IDLE.
REQ-038 start_i asserted while busy_o=1 -> no effect on counters or the stream.
